bomb_countdown_mux: RTL
=======================

# bomb_countdown_mux

Parametrised bomb countdown timer with multiplexed seven-segment output. It loads a decimal start value and counts down once per divided tick after `start`. It freezes on `success` (defused) or at zero (expired). It drives up to eight common-cathode digits through `cat`/`seg`. It sits between the game-control FSM and the board display, and extends the 2-digit, fixed-20 countdown with configurable digits, rates, explicit state and re-arm.

## Interface
- `DIGITS`, 2: number of BCD digits, 1..8.
- `START_VALUE`, 20: decimal load value, must be < 10^DIGITS.
- `TICK_DIV`, 1_000_000: clk cycles per countdown step, ≥ 2.
- `SCAN_DIV`, 1000: clk cycles each digit stays selected, ≥ 1.
- `clk` in 1: system clock.
- `rst` in 1: reset, **asynchronous, active-high** (one clock domain).
- `start` in 1: arm, sampled in IDLE only.
- `success` in 1: defuse, sampled in RUN only.
- `clear` in 1: return to IDLE and reload, any state.
- `cat` out 8: digit select, active-low; bit i = digit i (0 = units).
- `seg` out 8: segments {dp,g..a}, active-high; dp always 0.
- `bcd` out 4*DIGITS: current count, digit i at [4i+3:4i].
- `running` out 1: state == RUN.
- `defused` out 1: state == DEFUSED.
- `expired` out 1: state == EXPIRED.

## Operation
- States: IDLE, RUN, DEFUSED, EXPIRED. Reset → IDLE, `bcd` = START_VALUE.
- IDLE: `start`=1 → RUN, tick counter cleared.
- RUN: a tick pulses every TICK_DIV cycles. On a tick with count ≠ 0, count decrements in BCD, with a borrow rippling through digits (e.g. 10 → 09, 100 → 099). On a tick with count == 0 → EXPIRED, count stays 0.
- RUN: `success`=1 → DEFUSED, count frozen at its current value.
- DEFUSED and EXPIRED are terminal until `clear`. `start` and `success` are ignored there.
- Priority in a cycle: `clear` > `success` > tick.
  - `success` on the tick cycle: no decrement, go to DEFUSED.
  - `clear` in any state: IDLE, count = START_VALUE, tick counter = 0.
- `start` outside IDLE and `success` outside RUN have no effect.
- Display scan index cycles 0..DIGITS-1, advancing every SCAN_DIV cycles, free-running in every state.
  - `cat` = all ones except bit[index] = 0. Bits ≥ DIGITS are always 1.
  - `seg` is digit[index] decoded: 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F, non-BCD = 00.
  - In EXPIRED, every digit shows dash 0x40.
- All arithmetic is unsigned BCD; no digit ever holds a value > 9.

## Timing
- All outputs are registered.
- Reset values: `cat` = 8'hFF, `seg` = 8'h00, `bcd` = START_VALUE, `running` = `defused` = `expired` = 0.
- `start` sampled at edge N: `running` = 1 after edge N. The first decrement is visible after edge N+TICK_DIV, then every TICK_DIV cycles.
- From START_VALUE = V, `expired` rises TICK_DIV·(V+1) cycles after the start edge.
- `success`/`clear` take effect on the next edge; status outputs update the same edge.
- `cat`/`seg` update together, one cycle after the scan index changes. They never show a stale digit with a new select.
- `rst` mid-run immediately forces all reset values, independent of `clk`.

## Structure
- Shared package `bomb_pkg`:
  - state enum;
  - seven-segment constants (digit codes 0..9, `SEG_DASH` = 8'h40, `SEG_BLANK` = 8'h00).
- One sub-module `bcd_to_seg7` (combinational, 4-bit BCD → 8-bit seg).
- Top holds the FSM, tick divider, BCD down-counter array (generate loop over DIGITS) and scan counter.

## Test plan
All scenarios use DIGITS=2, START_VALUE=20, TICK_DIV=4, SCAN_DIV=2 unless noted.
- Reset, then idle 20 cycles → `bcd` = 8'h20, state IDLE. `cat` alternates FE/FD every 2 cycles with `seg` 3F/5B.
- `start` pulse, run to the end → `bcd` steps 20,19,…,00, one step per 4 cycles. `expired` = 1 exactly 84 cycles after start, `seg` = 40 on both digits.
- `start`, then `success` when `bcd` = 8'h13 → `defused` = 1 and `bcd` holds 13 for ≥ 50 cycles. Further `start`/`success` have no effect.
- `success` asserted on a tick cycle at `bcd` = 8'h10 → `bcd` stays 10, not 09, `defused` = 1.
- `clear` during RUN at 8'h07 → IDLE, `bcd` = 20, no tick within 3 cycles after re-`start`. `rst` asserted mid-run → all reset values without a clk edge.
- DIGITS=3, START_VALUE=100 → one tick gives `bcd` = 12'h099, and `cat` cycles FE/FD/FB.

Source files
------------

// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb countdown timer and its display.
package bomb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DEFUSED,
        ST_EXPIRED
    } state_t;

    localparam int MAX_DIGITS = 8;

    // Seven-segment codes, bit order {dp,g,f,e,d,c,b,a}, active-high.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Converts a decimal value to packed BCD, digit i at [4i+3:4i].
    function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int unsigned value);
        logic [4*MAX_DIGITS-1:0] result;
        int unsigned             rest;
        result = '0;
        rest   = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            result[4*i +: 4] = 4'(rest % 10);
            rest             = rest / 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/bomb_countdown_mux_bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder; non-BCD codes go blank.
module bcd_to_seg7
    import bomb_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        // NOTE: every path assigns seg (default arm included), so no latch is inferred.
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bomb_countdown_mux.sv
// Bomb countdown timer: BCD down-counter with arm/defuse/expire FSM and a
// multiplexed common-cathode seven-segment display driver.
module bomb_countdown_mux
    import bomb_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter int START_VALUE = 20,
    parameter int TICK_DIV    = 1_000_000,
    parameter int SCAN_DIV    = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                success,
    input  logic                clear,
    output logic [7:0]          cat,
    output logic [7:0]          seg,
    output logic [4*DIGITS-1:0] bcd,
    output logic                running,
    output logic                defused,
    output logic                expired
);

    localparam int BW     = 4 * DIGITS;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [4*MAX_DIGITS-1:0] START_FULL = to_bcd(START_VALUE);
    localparam logic [BW-1:0]           START_BCD  = START_FULL[BW-1:0];
    localparam logic [TICK_W-1:0]       TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0]       SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]        IDX_LAST   = IDX_W'(DIGITS - 1);

    state_t              state_q, state_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic [7:0]          cat_q, cat_d;
    logic [7:0]          seg_q, seg_d;
    logic                running_q, running_d;
    logic                defused_q, defused_d;
    logic                expired_q, expired_d;

    logic [BW-1:0]       dec_bcd;
    logic                tick;
    logic                scan_step;
    logic [3:0]          cur_digit;
    logic [7:0]          digit_seg;

    // BCD decrement of the whole count: a digit borrows only when every
    // lower digit is zero, so each digit wraps 0 -> 9 exactly then.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] cur;
        logic       borrow_in;
        assign cur = bcd_q[4*i +: 4];
        if (i == 0) begin : g_lsd
            assign borrow_in = 1'b1;
        end else begin : g_upper
            assign borrow_in = (bcd_q[4*i-1:0] == '0);
        end
        assign dec_bcd[4*i +: 4] = !borrow_in   ? cur   :
                                   (cur == 4'd0) ? 4'd9  : cur - 4'd1;
    end

    assign tick = (tick_q == TICK_LAST);

    // Next-state logic for the FSM, countdown value and tick divider.
    always_comb begin
        // NOTE: blocking assignments in combinational logic; defaults first hold state.
        state_d = state_q;
        bcd_d   = bcd_q;
        tick_d  = tick_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    tick_d  = '0;
                end
            end
            ST_RUN: begin
                tick_d = tick ? '0 : tick_q + TICK_W'(1);
                if (success) begin
                    state_d = ST_DEFUSED;
                end else if (tick) begin
                    if (bcd_q == '0) state_d = ST_EXPIRED;
                    else             bcd_d   = dec_bcd;
                end
            end
            default: ;  // DEFUSED and EXPIRED hold until clear
        endcase

        if (clear) begin
            state_d = ST_IDLE;
            bcd_d   = START_BCD;
            tick_d  = '0;
        end
    end

    assign running_d = (state_d == ST_RUN);
    assign defused_d = (state_d == ST_DEFUSED);
    assign expired_d = (state_d == ST_EXPIRED);

    // Free-running scan index plus select/segment pair derived from the
    // current index, so cat and seg always refer to the same digit.
    always_comb begin
        scan_step  = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_step ? '0 : scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_step) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
        end

        cat_d     = 8'hFF;
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                cat_d[i]  = 1'b0;
                cur_digit = bcd_q[4*i +: 4];
            end
        end
    end

    bcd_to_seg7 u_seg7 (
        .bcd (cur_digit),
        .seg (digit_seg)
    );

    assign seg_d = (state_q == ST_EXPIRED) ? SEG_DASH : digit_seg;

    // All state and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments for flops so every register samples pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            bcd_q      <= START_BCD;
            tick_q     <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            cat_q      <= 8'hFF;
            seg_q      <= SEG_BLANK;
            running_q  <= 1'b0;
            defused_q  <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            tick_q     <= tick_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            cat_q      <= cat_d;
            seg_q      <= seg_d;
            running_q  <= running_d;
            defused_q  <= defused_d;
            expired_q  <= expired_d;
        end
    end

    assign cat     = cat_q;
    assign seg     = seg_q;
    assign bcd     = bcd_q;
    assign running = running_q;
    assign defused = defused_q;
    assign expired = expired_q;

endmodule
